// File: rtl/stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
package stall_ctrl_pkg;

    // Controller state: normal issue, multi-cycle memory wait, latched fault
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } stall_state_e;

    // Sticky error causes reported on err_code
    localparam logic [1:0] ERR_NONE         = 2'd0;
    localparam logic [1:0] ERR_MEM_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_HAZ_DEADLOCK = 2'd2;

    // Width of the optional performance counters
    localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_VAL = WIDTH'(1);

    // Count up on inc, stick at all-ones, return to zero on clear
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + ONE_VAL;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller: turns hazard, branch and memory handshake into
// freeze/flush/bubble controls, with memory-timeout and hazard-deadlock
// watchdogs feeding a sticky error latch.
// Optional build macro STALL_PERF_EN adds three 32-bit saturating perf counters.
module pipeline_stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT      = 64,
    parameter int MAX_HAZARD_STALL = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hazard_detected,
    input  logic       branch_taken,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_freeze,
    output logic       if_id_flush,
    output logic       id_exe_bubble,
    output logic       pipe_freeze,
    output logic       ctrl_error,
    output logic [1:0] err_code
`ifdef STALL_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_freeze_cycles,
    output logic [PERF_CNT_W-1:0] perf_hazard_stalls,
    output logic [PERF_CNT_W-1:0] perf_flushes
`endif
);

    localparam int MEM_CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int HAZ_CNT_W = $clog2(MAX_HAZARD_STALL + 1);
    localparam logic [MEM_CNT_W-1:0] MEM_LAST = MEM_CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [HAZ_CNT_W-1:0] HAZ_LAST = HAZ_CNT_W'(MAX_HAZARD_STALL - 1);

    stall_state_e          state_r;
    stall_state_e          state_nxt_s;
    logic [1:0]            err_code_r;
    logic [1:0]            err_nxt_s;
    logic                  ctrl_error_r;

    logic [MEM_CNT_W-1:0]  mem_cnt_s;
    logic [HAZ_CNT_W-1:0]  haz_cnt_s;
    logic                  mem_clr_s;
    logic                  mem_inc_s;
    logic                  haz_clr_s;
    logic                  haz_inc_s;

    logic                  run_eval_s;
    logic                  pc_freeze_s;
    logic                  flush_s;
    logic                  bubble_s;
    logic                  pipe_freeze_s;
    logic                  haz_stall_s;

    // Memory-wait watchdog counter
    sat_counter #(.WIDTH(MEM_CNT_W)) u_mem_cnt (
        .clk   (clk),
        .clear (rst | mem_clr_s),
        .inc   (mem_inc_s),
        .count (mem_cnt_s)
    );

    // Consecutive hazard-stall watchdog counter
    sat_counter #(.WIDTH(HAZ_CNT_W)) u_haz_cnt (
        .clk   (clk),
        .clear (rst | haz_clr_s),
        .inc   (haz_inc_s),
        .count (haz_cnt_s)
    );

    // Next state, counter control and same-cycle stall outputs
    always_comb begin
        state_nxt_s   = state_r;
        err_nxt_s     = err_code_r;
        mem_clr_s     = 1'b0;
        mem_inc_s     = 1'b0;
        haz_clr_s     = 1'b0;
        haz_inc_s     = 1'b0;
        run_eval_s    = 1'b0;
        pc_freeze_s   = 1'b0;
        flush_s       = 1'b0;
        bubble_s      = 1'b0;
        pipe_freeze_s = 1'b0;
        haz_stall_s   = 1'b0;

        case (state_r)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    // haz_cnt holds: the ID instruction is frozen, not retried
                    pipe_freeze_s = 1'b1;
                    mem_inc_s     = 1'b1;
                    state_nxt_s   = MEM_WAIT;
                end else begin
                    run_eval_s = 1'b1;
                end
            end
            MEM_WAIT: begin
                // mem_req is ignored here: a dropped request still counts as waiting
                if (mem_ready) begin
                    mem_clr_s   = 1'b1;
                    state_nxt_s = RUN;
                    run_eval_s  = 1'b1;
                end else if (mem_cnt_s == MEM_LAST) begin
                    pipe_freeze_s = 1'b1;
                    state_nxt_s   = ERROR;
                    err_nxt_s     = ERR_MEM_TIMEOUT;
                end else begin
                    pipe_freeze_s = 1'b1;
                    mem_inc_s     = 1'b1;
                end
            end
            ERROR: begin
                pipe_freeze_s = 1'b1;
                pc_freeze_s   = 1'b1;
            end
            default: begin
                state_nxt_s = RUN;
                mem_clr_s   = 1'b1;
                haz_clr_s   = 1'b1;
            end
        endcase

        // Branch beats hazard: a squashed ID instruction needs no stall
        if (run_eval_s) begin
            if (branch_taken) begin
                flush_s   = 1'b1;
                bubble_s  = 1'b1;
                haz_clr_s = 1'b1;
            end else if (hazard_detected) begin
                pc_freeze_s = 1'b1;
                bubble_s    = 1'b1;
                haz_stall_s = 1'b1;
                haz_inc_s   = 1'b1;
                if (haz_cnt_s == HAZ_LAST) begin
                    state_nxt_s = ERROR;
                    err_nxt_s   = ERR_HAZ_DEADLOCK;
                end else begin
                    state_nxt_s = state_nxt_s;
                end
            end else begin
                haz_clr_s = 1'b1;
            end
        end else begin
            haz_stall_s = 1'b0;
        end
    end

    // State, sticky error code and error flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= RUN;
            err_code_r   <= ERR_NONE;
            ctrl_error_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            err_code_r   <= err_nxt_s;
            ctrl_error_r <= (err_nxt_s != ERR_NONE);
        end
    end

    // Reset forces every control low in the reset cycle itself
    assign pc_freeze     = ~rst & pc_freeze_s;
    assign if_id_flush   = ~rst & flush_s;
    assign id_exe_bubble = ~rst & bubble_s;
    assign pipe_freeze   = ~rst & pipe_freeze_s;
    assign ctrl_error    = ~rst & ctrl_error_r;
    assign err_code      = rst ? ERR_NONE : err_code_r;

`ifdef STALL_PERF_EN
    // Cycles with the whole pipeline held
    sat_counter #(.WIDTH(PERF_CNT_W)) u_perf_freeze (
        .clk   (clk),
        .clear (rst),
        .inc   (pipe_freeze_s),
        .count (perf_freeze_cycles)
    );

    // Cycles stalled by a RAW hazard
    sat_counter #(.WIDTH(PERF_CNT_W)) u_perf_hazard (
        .clk   (clk),
        .clear (rst),
        .inc   (haz_stall_s),
        .count (perf_hazard_stalls)
    );

    // Taken-branch flushes
    sat_counter #(.WIDTH(PERF_CNT_W)) u_perf_flush (
        .clk   (clk),
        .clear (rst),
        .inc   (flush_s),
        .count (perf_flushes)
    );
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed, table-driven bench for pipeline_stall_ctrl (MEM_TIMEOUT=4,
// MAX_HAZARD_STALL=8). Output vector order: {pc_freeze, if_id_flush,
// id_exe_bubble, pipe_freeze, ctrl_error}.
module tb_pipeline_stall_ctrl;

    localparam logic [4:0] O_IDLE = 5'b00000;
    localparam logic [4:0] O_HAZ  = 5'b10100;
    localparam logic [4:0] O_BR   = 5'b01100;
    localparam logic [4:0] O_FRZ  = 5'b00010;
    localparam logic [4:0] O_ERR  = 5'b10011;

    typedef struct {
        logic       rst;
        logic       hz;
        logic       br;
        logic       mr;
        logic       rdy;
        logic [4:0] exp_out;
        logic [1:0] exp_err;
        string      name;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       hazard_detected;
    logic       branch_taken;
    logic       mem_req;
    logic       mem_ready;
    logic       pc_freeze;
    logic       if_id_flush;
    logic       id_exe_bubble;
    logic       pipe_freeze;
    logic       ctrl_error;
    logic [1:0] err_code;
`ifdef STALL_PERF_EN
    logic [31:0] perf_freeze_cycles;
    logic [31:0] perf_hazard_stalls;
    logic [31:0] perf_flushes;
`endif

    int   checks;
    int   errors;
    vec_t tbl[$];

    pipeline_stall_ctrl #(
        .MEM_TIMEOUT      (4),
        .MAX_HAZARD_STALL (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .branch_taken    (branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_freeze       (pc_freeze),
        .if_id_flush     (if_id_flush),
        .id_exe_bubble   (id_exe_bubble),
        .pipe_freeze     (pipe_freeze),
        .ctrl_error      (ctrl_error),
        .err_code        (err_code)
`ifdef STALL_PERF_EN
        ,
        .perf_freeze_cycles (perf_freeze_cycles),
        .perf_hazard_stalls (perf_hazard_stalls),
        .perf_flushes       (perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic hz, input logic br,
                                input logic mr, input logic rdy,
                                input logic [4:0] eo, input logic [1:0] ee,
                                input string nm);
        vec_t v;
        v.rst = r; v.hz = hz; v.br = br; v.mr = mr; v.rdy = rdy;
        v.exp_out = eo; v.exp_err = ee; v.name = nm;
        tbl.push_back(v);
    endfunction

    // One cycle: drive inputs after the edge, sample mid-cycle, advance
    task automatic cyc(input logic r, input logic hz, input logic br,
                       input logic mr, input logic rdy,
                       input logic [4:0] eo, input logic [1:0] ee,
                       input string nm);
        logic [4:0] got;
        rst             = r;
        hazard_detected = hz;
        branch_taken    = br;
        mem_req         = mr;
        mem_ready       = rdy;
        @(negedge clk);
        got = {pc_freeze, if_id_flush, id_exe_bubble, pipe_freeze, ctrl_error};
        checks++;
        if (got !== eo || err_code !== ee) begin
            errors++;
            $display("FAIL %s: got outs=%b err_code=%0d, want outs=%b err_code=%0d",
                     nm, got, err_code, eo, ee);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        hazard_detected = 1'b0;
        branch_taken = 1'b0;
        mem_req = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;

        //   rst  hz    br    mr    rdy   expected  err
        add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, O_IDLE, 2'd0, "reset_inputs_high");
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 2'd0, "reset_quiet");
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 2'd0, "idle");
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_HAZ,  2'd0, "hazard_1");
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_HAZ,  2'd0, "hazard_2");
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 2'd0, "hazard_release");
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, O_BR,   2'd0, "branch_over_hazard");
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_BR,   2'd0, "branch_only");
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_IDLE, 2'd0, "mem_single_cycle");
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_FRZ,  2'd0, "mem_wait_1");
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_FRZ,  2'd0, "mem_wait_2");
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, O_FRZ,  2'd0, "mem_wait_3_masks_br_hz");
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, O_HAZ,  2'd0, "mem_release_hazard");
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 2'd0, "back_in_run");
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_FRZ,  2'd0, "drop_req_wait_1");
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_FRZ,  2'd0, "drop_req_still_frozen");
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_IDLE, 2'd0, "drop_req_release");
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 2'd0, "idle_after_drop");

        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].hz, tbl[i].br, tbl[i].mr, tbl[i].rdy,
                tbl[i].exp_out, tbl[i].exp_err, tbl[i].name);
        end

        // Hazard count survives a memory wait: 6 + release + 1 reaches the limit
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_HAZ, 2'd0, "hold_haz");
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_FRZ, 2'd0, "hold_mem_stall");
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_FRZ, 2'd0, "hold_mem_wait");
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, O_HAZ, 2'd0, "hold_release_haz7");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_HAZ, 2'd0, "hold_haz8");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_ERR, 2'd2, "hold_deadlock_err");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 2'd0, "hold_reset");

        // One short of the hazard limit: no error
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_HAZ, 2'd0, "haz_below_limit");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 2'd0, "haz_below_limit_ok");

        // Hazard deadlock, then ERROR outranks branch and memory inputs
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_HAZ, 2'd0, "deadlock_haz");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_ERR, 2'd2, "deadlock_err");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, O_ERR, 2'd2, "deadlock_branch_ignored");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_ERR, 2'd2, "deadlock_mem_ignored");
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, O_IDLE, 2'd0, "deadlock_reset");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 2'd0, "deadlock_cleared");

        // Memory timeout: 4 frozen cycles then sticky ERROR
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_FRZ, 2'd0, "timeout_wait");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_ERR, 2'd1, "timeout_err");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_ERR, 2'd1, "timeout_ready_ignored");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_ERR, 2'd1, "timeout_cause_kept");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 2'd0, "timeout_reset");

        // Reset mid-wait at the last count; fresh request counts from 1
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_FRZ, 2'd0, "midwait_wait");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, O_IDLE, 2'd0, "midwait_reset");
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_FRZ, 2'd0, "midwait_fresh_wait");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_ERR, 2'd1, "midwait_fresh_timeout");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
